// File: rtl/ingress_rr_mux.sv
// Round-robin ingress aggregator: moves whole frames from per-port rx FIFO pairs
// into shared data/descriptor FIFOs, tagging each frame with its one-hot source port.

module ingress_rr_mux_fifo #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic [AW:0]  cnt
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_wr;
   logic          do_rd;

   assign empty = (cnt == '0);
   assign do_wr = wr && (cnt != DEPTH);
   assign do_rd = rd && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= din;
   end

   // Standard-read FIFO: dout updates only on an accepted pop and otherwise holds.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         dout <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) begin
            rptr <= rptr + 1'b1;
            dout <= mem[rptr];
         end
         if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
         else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
      end
   end
endmodule

module ingress_rr_mux #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int LEN_W     = 11,
   parameter int DFIFO_AW  = 12,
   parameter int PFIFO_AW  = 5
) (
   input  logic                        clk,
   input  logic                        rstn,
   output logic [NUM_PORTS-1:0]        rx_ptr_fifo_rd,
   input  logic [16*NUM_PORTS-1:0]     rx_ptr_fifo_dout,
   input  logic [NUM_PORTS-1:0]        rx_ptr_fifo_empty,
   output logic [NUM_PORTS-1:0]        rx_data_fifo_rd,
   input  logic [DATA_W*NUM_PORTS-1:0] rx_data_fifo_dout,
   input  logic                        sfifo_rd,
   output logic [DATA_W-1:0]           sfifo_dout,
   output logic                        sfifo_empty,
   output logic [DFIFO_AW:0]           sfifo_cnt,
   input  logic                        ptr_sfifo_rd,
   output logic [NUM_PORTS+LEN_W:0]    ptr_sfifo_dout,
   output logic                        ptr_sfifo_empty,
   output logic [15:0]                 drop_cnt
);
   localparam int SEL_W  = $clog2(NUM_PORTS);
   localparam int DESC_W = 1 + NUM_PORTS + LEN_W;

   typedef enum logic [2:0] {IDLE, PTR_LAT, HDR, DATA, TAIL, PTR_WR} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [SEL_W-1:0]      rr_ptr;
   logic [SEL_W-1:0]      sel;
   logic [SEL_W-1:0]      grant;
   logic                  grant_vld;
   logic                  grant_take;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      remain;
   logic [LEN_W-1:0]      hdr_len;
   logic                  err_q;
   logic                  hdr_err;
   logic                  hdr_fits;
   logic                  data_wr;
   logic                  ptr_wr;
   logic                  drop_inc;
   logic [PFIFO_AW:0]     ptr_cnt;
   logic                  ptr_full;
   logic [NUM_PORTS-1:0]  src_onehot;
   logic [DESC_W-1:0]     ptr_din;
   logic [DATA_W-1:0]     data_din;

   assign hdr_len    = rx_ptr_fifo_dout[16*sel +: LEN_W];
   assign hdr_err    = rx_ptr_fifo_dout[16*sel + 15] | rx_ptr_fifo_dout[16*sel + 14];
   assign hdr_fits   = ((2**DFIFO_AW) - int'(sfifo_cnt)) >= int'(hdr_len);
   assign ptr_full   = (ptr_cnt == (PFIFO_AW+1)'(2**PFIFO_AW));
   assign grant_take = (state == IDLE) && grant_vld && !ptr_full;
   assign src_onehot = NUM_PORTS'(1) << sel;
   assign ptr_din    = {1'b0, src_onehot, len_q};
   assign data_din   = rx_data_fifo_dout[DATA_W*sel +: DATA_W];

   // Descending scan so the lowest cyclic offset from rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (!rx_ptr_fifo_empty[(int'(rr_ptr) + i) % NUM_PORTS]) begin
            grant_vld = 1'b1;
            grant     = SEL_W'((int'(rr_ptr) + i) % NUM_PORTS);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      rx_ptr_fifo_rd  = '0;
      rx_data_fifo_rd = '0;
      ptr_wr          = 1'b0;
      drop_inc        = 1'b0;
      case (state)
         IDLE: begin
            if (grant_take) begin
               rx_ptr_fifo_rd[grant] = 1'b1;
               state_nxt             = PTR_LAT;
            end
         end
         PTR_LAT: state_nxt = HDR;
         HDR: begin
            if (hdr_len == '0) begin
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end else if (hdr_err || hdr_fits) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            rx_data_fifo_rd[sel] = 1'b1;
            if (remain == LEN_W'(1)) state_nxt = TAIL;
         end
         TAIL: state_nxt = PTR_WR;
         PTR_WR: begin
            ptr_wr    = !err_q;
            drop_inc  = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shared-FIFO write trails the upstream pop by one cycle, matching its read latency.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr   <= '0;
         sel      <= '0;
         len_q    <= '0;
         remain   <= '0;
         err_q    <= 1'b0;
         data_wr  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         data_wr <= (state == DATA) && !err_q;
         if (grant_take) begin
            sel    <= grant;
            rr_ptr <= (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
         end
         if (state == HDR) begin
            len_q  <= hdr_len;
            err_q  <= hdr_err;
            remain <= hdr_len;
         end else if (state == DATA) begin
            remain <= remain - 1'b1;
         end
         if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   ingress_rr_mux_fifo #(.AW(DFIFO_AW), .W(DATA_W)) u_data_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .wr    (data_wr),
      .din   (data_din),
      .rd    (sfifo_rd),
      .dout  (sfifo_dout),
      .empty (sfifo_empty),
      .cnt   (sfifo_cnt)
   );

   ingress_rr_mux_fifo #(.AW(PFIFO_AW), .W(DESC_W)) u_ptr_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .wr    (ptr_wr),
      .din   (ptr_din),
      .rd    (ptr_sfifo_rd),
      .dout  (ptr_sfifo_dout),
      .empty (ptr_sfifo_empty),
      .cnt   (ptr_cnt)
   );
endmodule

// File: doc/ingress_rr_mux.md
# ingress_rr_mux

Parametrised N-port ingress aggregator for the switch front end. It arbitrates round-robin among per-port receive FIFO pairs (a pointer/descriptor FIFO and a byte data FIFO) and moves one whole frame at a time into a shared internal data FIFO and descriptor FIFO for the switching core. It tags every frame with its one-hot source port. It admits a frame only when the shared buffers can hold it in full, drops frames flagged as errored, and counts those drops.

## Interface
- NUM_PORTS, 4: number of ingress ports (2..8).
- DATA_W, 8: data byte-lane width.
- LEN_W, 11: frame length field width, in words (≤14).
- DFIFO_AW, 12: shared data FIFO address width (depth 2^DFIFO_AW).
- PFIFO_AW, 5: shared descriptor FIFO address width.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- rx_ptr_fifo_rd  out  NUM_PORTS  per-port descriptor pop.
- rx_ptr_fifo_dout  in  16*NUM_PORTS  per-port descriptor; [LEN_W-1:0] length, [15:14] error flags; port p at [16p+15:16p].
- rx_ptr_fifo_empty  in  NUM_PORTS  per-port descriptor FIFO empty.
- rx_data_fifo_rd  out  NUM_PORTS  per-port data pop.
- rx_data_fifo_dout  in  DATA_W*NUM_PORTS  per-port data word.
- sfifo_rd  in  1  shared data FIFO pop.
- sfifo_dout  out  DATA_W  shared data word.
- sfifo_empty  out  1  shared data FIFO empty.
- sfifo_cnt  out  DFIFO_AW+1  shared data FIFO occupancy.
- ptr_sfifo_rd  in  1  descriptor pop.
- ptr_sfifo_dout  out  1+NUM_PORTS+LEN_W  {1'b0, source one-hot, length}.
- ptr_sfifo_empty  out  1  descriptor FIFO empty.
- drop_cnt  out  16  errored/zero-length frames dropped, saturating.

## Operation
- All upstream and internal FIFOs are standard-read: dout is valid the cycle after rd is high.
- States: IDLE, PTR_LAT, HDR, DATA, TAIL, PTR_WR.
- IDLE: if the descriptor FIFO is not full and some port is non-empty, grant the first non-empty port at or after rr_ptr (cyclic). Pulse that port's rx_ptr_fifo_rd for one cycle, latch sel, set rr_ptr = (grant+1) mod NUM_PORTS, go to PTR_LAT.
- PTR_LAT: no action; go to HDR.
- HDR: latch len = dout[LEN_W-1:0] and err = dout[15]|dout[14].
  - If len==0: drop_cnt++, go to IDLE; no data is read.
  - If err: go to DATA; no space check.
  - Otherwise wait in HDR until free = 2^DFIFO_AW − sfifo_cnt ≥ len, then go to DATA.
- DATA: assert rx_data_fifo_rd[sel] for exactly len consecutive cycles, then go to TAIL.
- Shared-FIFO write is the data rd delayed one cycle, gated by !err; sfifo_din is rx_data_fifo_dout[sel].
- TAIL: the last data write occurs; go to PTR_WR.
- PTR_WR: if !err, write the descriptor {0, 1<<sel, len}; if err, drop_cnt++. Go to IDLE.
- Only one frame is in flight at a time. rr_ptr is not touched outside IDLE grants.
- Shared FIFOs: a write when full is ignored; the admission check makes this unreachable for data. A read when empty is ignored and dout holds. Simultaneous read and write leaves the count unchanged. Pointers wrap modulo depth.
- drop_cnt holds at 0xFFFF.

## Timing
- Reset values:
  - rx_ptr_fifo_rd, rx_data_fifo_rd = 0.
  - sfifo_empty = ptr_sfifo_empty = 1.
  - sfifo_cnt = 0, drop_cnt = 0.
  - sfifo_dout and ptr_sfifo_dout = 0.
  - state = IDLE, rr_ptr = 0.
- Reset mid-frame aborts the frame and empties the shared FIFOs. Upstream FIFOs are untouched: a partially read frame stays partially read, and resynchronising it is the system's responsibility.
- Grant at cycle T0 (ptr rd high) → HDR at T2 → first data rd at T3 with no space wait.
  - Data writes occur T4..T3+len.
  - Descriptor write at T4+len.
  - IDLE at T5+len; next grant earliest at T5+len.
- Each HDR wait cycle delays all of the above by one.
- A descriptor appears only after all of its data words are in the shared FIFO: ptr_sfifo_empty falls at T5+len, sfifo_empty falls at T5.
- sfifo_cnt updates the cycle after a write or read.

## Test plan
- Port 0 single frame, len=4, data 0xA0..A3 → sfifo holds A0..A3; descriptor {0,0001,4} at T0+8; ptr_sfifo_empty low at T0+9.
- All 4 ports loaded with 2 frames each, rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; source fields match.
- Port 2 frame len=6 with dout[15]=1 → 6 data pops, no sfifo or descriptor writes, drop_cnt=1; the next frame is accepted normally.
- sfifo_cnt=4090 (DFIFO_AW=12), pending len=10 → stalls in HDR with no data rd; after sfifo_rd drains 4 words the frame proceeds, and sfifo_cnt never exceeds 4096.
- len=0 descriptor → no data rd, drop_cnt=1, IDLE at T0+3; descriptor FIFO full (32 entries) → no grant until ptr_sfifo_rd.
- rstn low during DATA of a len=100 frame → all outputs return to reset values asynchronously; after release, rr_ptr=0 and arbitration restarts.
